switch_tick_conditioner: RTL and testbench

Input-conditioning stage directly upstream of the game FSM. It synchronises and debounces the raw board switch, then drives the game's `switch` input with a clean level and edge pulses. It also generates the single-cycle `tick` enable that paces the game's 0..15 counter, so the counter advances at a visible rate instead of at the raw clock rate.

---
 rtl/switch_tick_conditioner_pkg.sv | 14 +
 rtl/switch_tick_conditioner_tick_gen.sv | 51 +++++
 rtl/switch_tick_conditioner.sv | 130 +++++++++++++
 tb/tb_switch_tick_conditioner.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_tick_conditioner_pkg.sv
// Shared constants for the switch/tick conditioner and the game FSM simulation builds:
// debounce state encoding and default timing parameters.
package switch_tick_conditioner_pkg;

  localparam logic [1:0] S_LOW       = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW  = 2'd3;

  // 10 ms debounce and 0.5 s tick at a 50 MHz clock
  localparam int DB_CYCLES_DEF = 500000;
  localparam int TICK_DIV_DEF  = 25000000;

endpackage

// File: rtl/switch_tick_conditioner_tick_gen.sv
// Tick prescaler: one-cycle registered pulse every TICK_DIV clocks, restartable by tick_clr.
module tick_gen
  import switch_tick_conditioner_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_clr,
  output logic tick
);

  // A divider of 1 still needs a one-bit counter so the terminal compare stays legal
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] ps_cnt_r;
  logic [PW-1:0] ps_cnt_s;
  logic          tick_s;
  logic          tick_r;

  // Next prescaler value and tick decision; tick_clr overrides a coinciding terminal count
  always_comb begin
    ps_cnt_s = ps_cnt_r;
    tick_s   = 1'b0;
    if (tick_clr) begin
      ps_cnt_s = {PW{1'b0}};
      tick_s   = 1'b0;
    end else if (ps_cnt_r == PS_LAST) begin
      ps_cnt_s = {PW{1'b0}};
      tick_s   = 1'b1;
    end else begin
      ps_cnt_s = ps_cnt_r + PW'(1);
      tick_s   = 1'b0;
    end
  end

  // Prescaler and tick registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_r <= {PW{1'b0}};
      tick_r   <= 1'b0;
    end else begin
      ps_cnt_r <= ps_cnt_s;
      tick_r   <= tick_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/switch_tick_conditioner.sv
// Synchronises and debounces the raw board switch into a clean level plus edge pulses,
// and paces the game counter with a prescaled tick.
module switch_tick_conditioner
  import switch_tick_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  input  logic tick_clr,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall,
  output logic tick
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          s1_r;
  logic          sync_r;
  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          level_r;
  logic          level_s;
  logic          rise_r;
  logic          rise_s;
  logic          fall_r;
  logic          fall_s;

  // Two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r   <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      s1_r   <= sw_raw;
      sync_r <= s1_r;
    end
  end

  // Debounce next-state logic; the count only advances inside a WAIT state and stops at DB_LAST
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = level_r;
    rise_s  = 1'b0;
    fall_s  = 1'b0;
    case (state_r)
      S_LOW: begin
        if (sync_r) begin
          state_s = S_WAIT_HIGH;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = S_LOW;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync_r) begin
          state_s = S_LOW;
        end else if (cnt_r == DB_LAST) begin
          state_s = S_HIGH;
          level_s = 1'b1;
          rise_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      S_HIGH: begin
        if (!sync_r) begin
          state_s = S_WAIT_LOW;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = S_HIGH;
        end
      end
      S_WAIT_LOW: begin
        if (sync_r) begin
          state_s = S_HIGH;
        end else if (cnt_r == DB_LAST) begin
          state_s = S_LOW;
          level_s = 1'b0;
          fall_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = S_LOW;
        cnt_s   = {CW{1'b0}};
        level_s = 1'b0;
      end
    endcase
  end

  // Debounce state, count and registered switch outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_LOW;
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
    end
  end

  assign sw_level = level_r;
  assign sw_rise  = rise_r;
  assign sw_fall  = fall_r;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_clr (tick_clr),
    .tick     (tick)
  );

endmodule

// File: tb/tb_switch_tick_conditioner.sv
// Directed bench for switch_tick_conditioner with DB_CYCLES=4, TICK_DIV=5.
module tb_switch_tick_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_raw = 1'b0;
  logic tick_clr = 1'b0;
  logic sw_level;
  logic sw_rise;
  logic sw_fall;
  logic tick;

  int errors = 0;
  int checks = 0;

  switch_tick_conditioner #(
    .DB_CYCLES(4),
    .TICK_DIV (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .tick_clr (tick_clr),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] exp_v;
    rst_n = 1'b0; sw_raw = 1'b0; tick_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sw_level, sw_rise, sw_fall, tick} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=0000", {sw_level, sw_rise, sw_fall, tick});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk); #1;
      exp_v = {3'b000, (e == 5 || e == 10 || e == 15)};
      checks++;
      if ({sw_level, sw_rise, sw_fall, tick} !== exp_v) begin
        errors++;
        $display("FAIL idle_tick edge=%0d got=%b exp=%b", e, {sw_level, sw_rise, sw_fall, tick}, exp_v);
      end
    end
  endtask

  task automatic test_rise();
    logic [2:0] exp_v;
    sw_raw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      exp_v = {(e >= 7), (e == 7), 1'b0};
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== exp_v) begin
        errors++;
        $display("FAIL rise edge=%0d got=%b exp=%b", e, {sw_level, sw_rise, sw_fall}, exp_v);
      end
    end
  endtask

  task automatic test_fall();
    logic [2:0] exp_v;
    // two-cycle low glitch while high must be ignored
    sw_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 2) sw_raw = 1'b1;
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== 3'b100) begin
        errors++;
        $display("FAIL low_glitch edge=%0d got=%b exp=100", e, {sw_level, sw_rise, sw_fall});
      end
    end
    sw_raw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      exp_v = {(e < 7), 1'b0, (e == 7)};
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== exp_v) begin
        errors++;
        $display("FAIL fall edge=%0d got=%b exp=%b", e, {sw_level, sw_rise, sw_fall}, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] exp_v;
    // high for edges 1-3, low for 4-5, high from edge 6 onward
    sw_raw = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (e == 3) sw_raw = 1'b0;
      if (e == 5) sw_raw = 1'b1;
      exp_v = {(e >= 12), (e == 12), 1'b0};
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== exp_v) begin
        errors++;
        $display("FAIL bounce edge=%0d got=%b exp=%b", e, {sw_level, sw_rise, sw_fall}, exp_v);
      end
    end
  endtask

  task automatic test_tick_clr();
    int seen;
    seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (tick === 1'b1) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      errors++;
      $display("FAIL tick_align got=no_tick exp=tick_within_8");
    end else begin
      for (int e = 1; e <= 4; e++) begin
        @(posedge clk); #1;
        checks++;
        if (tick !== 1'b0) begin
          errors++;
          $display("FAIL tick_pre_clr edge=%0d got=%b exp=0", e, tick);
        end
      end
      // prescaler is at its terminal count: clear on this edge
      tick_clr = 1'b1;
      @(posedge clk); #1;
      tick_clr = 1'b0;
      checks++;
      if (tick !== 1'b0) begin
        errors++;
        $display("FAIL tick_clr_suppress got=%b exp=0", tick);
      end
      for (int e = 1; e <= 7; e++) begin
        @(posedge clk); #1;
        checks++;
        if (tick !== (e == 5)) begin
          errors++;
          $display("FAIL tick_after_clr edge=%0d got=%b exp=%b", e, tick, (e == 5));
        end
      end
    end
  endtask

  task automatic pulse_reset_and_check(input string name);
    logic [3:0] exp_v;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_level, sw_rise, sw_fall, tick} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_async got=%b exp=0000", name, {sw_level, sw_rise, sw_fall, tick});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      exp_v = {(e >= 7), (e == 7), 1'b0, (e == 5 || e == 10)};
      checks++;
      if ({sw_level, sw_rise, sw_fall, tick} !== exp_v) begin
        errors++;
        $display("FAIL %s_redo edge=%0d got=%b exp=%b", name, e, {sw_level, sw_rise, sw_fall, tick}, exp_v);
      end
    end
  endtask

  task automatic test_reset_high();
    // switch accepted high and still held: reset must clear the level at once
    sw_raw = 1'b1;
    pulse_reset_and_check("reset_high");
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_v;
    sw_raw = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      exp_v = {(e < 7), 1'b0, (e == 7)};
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== exp_v) begin
        errors++;
        $display("FAIL pre_mid_fall edge=%0d got=%b exp=%b", e, {sw_level, sw_rise, sw_fall}, exp_v);
      end
    end
    // four edges into the press leaves the debouncer inside S_WAIT_HIGH
    sw_raw = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      checks++;
      if ({sw_level, sw_rise, sw_fall} !== 3'b000) begin
        errors++;
        $display("FAIL wait_high edge=%0d got=%b exp=000", e, {sw_level, sw_rise, sw_fall});
      end
    end
    pulse_reset_and_check("reset_mid");
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_bounce();
    test_tick_clr();
    test_reset_high();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
